// File: rtl/c_guess_engine_if.sv
// Bus between the computer guess engine and the player-board logic:
// turn/phase/select controls in, hit results back, guess masks out.
interface c_guess_engine_if #(
  parameter int CELLS = 28,
  parameter int IDXW  = $clog2(CELLS)
) ();
  logic             sel;
  logic             sw;
  logic             phase;
  logic             hit_valid;
  logic             hit;
  logic [CELLS-1:0] comp_guess;
  logic [CELLS-1:0] sing_guess;
  logic [IDXW-1:0]  guess_idx;
  logic             guess_valid;
  logic             busy;
  logic             done;

  modport master (
    input  sel, sw, phase, hit_valid, hit,
    output comp_guess, sing_guess, guess_idx, guess_valid, busy, done
  );

  modport slave (
    output sel, sw, phase, hit_valid, hit,
    input  comp_guess, sing_guess, guess_idx, guess_valid, busy, done
  );
endinterface

// File: rtl/c_guess_engine.sv
// Computer-opponent guess generator: LFSR hunt mode that never repeats a cell,
// plus a LIFO target mode that fires on the neighbours of confirmed hits.
module c_guess_engine #(
  parameter int         ROWS      = 4,
  parameter int         COLS      = 7,
  parameter int         CELLS     = ROWS * COLS,
  parameter int         IDXW      = $clog2(CELLS),
  parameter int         TGT_DEPTH = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  c_guess_engine_if.master bus
);
  localparam int SPW  = $clog2(TGT_DEPTH + 1);
  localparam int CNTW = $clog2(CELLS + 1);

  typedef enum logic [2:0] {S_READY, S_SEEK, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        lfsr_reg, lfsr_next;
  logic [IDXW-1:0]   cand_reg, cand_next;
  logic [IDXW-1:0]   pick_reg, pick_next;
  logic [IDXW-1:0]   guess_idx_reg, guess_idx_next;
  logic [CELLS-1:0]  comp_reg, comp_next;
  logic [CELLS-1:0]  sing_reg, sing_next;
  logic              guess_valid_reg, guess_valid_next;
  logic [CNTW-1:0]   cnt_reg, cnt_next;
  logic [SPW-1:0]    sp_reg, sp_next;
  logic [IDXW-1:0]   stack_reg  [TGT_DEPTH];
  logic [IDXW-1:0]   stack_next [TGT_DEPTH];

  logic              req;
  logic [IDXW-1:0]   top;
  logic [3:0]        nb_ok;
  logic [IDXW-1:0]   nb_idx [4];
  int                nb_pos [4];
  int                nb_end;

  assign req       = bus.sw & bus.sel & bus.phase;
  assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

  // Neighbours of the last guess in push order N, S, W, E, with the stack
  // slot each one would land in; slots past the top of the stack are dropped.
  always_comb begin
    int g;
    int c;
    int base;
    logic [3:0] inb;
    g         = int'(guess_idx_reg);
    c         = g % COLS;
    inb[0]    = (g >= COLS);
    inb[1]    = (g + COLS < CELLS);
    inb[2]    = (c != 0);
    inb[3]    = (c != COLS - 1);
    nb_idx[0] = IDXW'(g - COLS);
    nb_idx[1] = IDXW'(g + COLS);
    nb_idx[2] = IDXW'(g - 1);
    nb_idx[3] = IDXW'(g + 1);
    nb_ok     = '0;
    base      = int'(sp_reg);
    for (int k = 0; k < 4; k++) begin
      nb_ok[k]  = inb[k] && !comp_reg[nb_idx[k]];
      nb_pos[k] = base;
      if (nb_ok[k]) base = base + 1;
    end
    nb_end = (base > TGT_DEPTH) ? TGT_DEPTH : base;
  end

  always_comb begin
    state_next       = state_reg;
    cand_next        = cand_reg;
    pick_next        = pick_reg;
    guess_idx_next   = guess_idx_reg;
    comp_next        = comp_reg;
    sing_next        = sing_reg;
    guess_valid_next = 1'b0;
    cnt_next         = cnt_reg;
    sp_next          = sp_reg;
    stack_next       = stack_reg;
    top              = '0;
    for (int e = 0; e < TGT_DEPTH; e++) begin
      if (int'(sp_reg) == e + 1) top = stack_reg[e];
    end

    case (state_reg)
      S_READY: begin
        if (req) begin
          state_next = S_SEEK;
          cand_next  = IDXW'(int'(lfsr_reg) % CELLS);
        end
      end
      S_SEEK: begin
        // Stale or duplicate stack entries are discarded here, one per cycle.
        if (sp_reg != '0) begin
          sp_next = sp_reg - 1'b1;
          if (!comp_reg[top]) begin
            pick_next  = top;
            state_next = S_ISSUE;
          end
        end else if (!comp_reg[cand_reg]) begin
          pick_next  = cand_reg;
          state_next = S_ISSUE;
        end else begin
          cand_next = (int'(cand_reg) == CELLS - 1) ? '0 : cand_reg + 1'b1;
        end
      end
      S_ISSUE: begin
        comp_next[pick_reg] = 1'b1;
        sing_next           = '0;
        sing_next[pick_reg] = 1'b1;
        guess_idx_next      = pick_reg;
        guess_valid_next    = 1'b1;
        cnt_next            = cnt_reg + 1'b1;
        state_next          = S_WAIT;
      end
      S_WAIT: begin
        if (bus.hit_valid) begin
          if (bus.hit) begin
            for (int e = 0; e < TGT_DEPTH; e++) begin
              for (int k = 0; k < 4; k++) begin
                if (nb_ok[k] && nb_pos[k] == e) stack_next[e] = nb_idx[k];
              end
            end
            sp_next = SPW'(nb_end);
          end
          state_next = (int'(cnt_reg) == CELLS) ? S_DONE : S_READY;
        end
      end
      S_DONE: begin
      end
      default: state_next = S_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_READY;
      lfsr_reg        <= LFSR_SEED;
      cand_reg        <= '0;
      pick_reg        <= '0;
      guess_idx_reg   <= '0;
      comp_reg        <= '0;
      sing_reg        <= '0;
      guess_valid_reg <= 1'b0;
      cnt_reg         <= '0;
      sp_reg          <= '0;
      for (int e = 0; e < TGT_DEPTH; e++) stack_reg[e] <= '0;
    end else begin
      state_reg       <= state_next;
      lfsr_reg        <= lfsr_next;
      cand_reg        <= cand_next;
      pick_reg        <= pick_next;
      guess_idx_reg   <= guess_idx_next;
      comp_reg        <= comp_next;
      sing_reg        <= sing_next;
      guess_valid_reg <= guess_valid_next;
      cnt_reg         <= cnt_next;
      sp_reg          <= sp_next;
      for (int e = 0; e < TGT_DEPTH; e++) stack_reg[e] <= stack_next[e];
    end
  end

  assign bus.comp_guess  = comp_reg;
  assign bus.sing_guess  = sing_reg;
  assign bus.guess_idx   = guess_idx_reg;
  assign bus.guess_valid = guess_valid_reg;
  assign bus.busy        = (state_reg == S_SEEK) || (state_reg == S_ISSUE) || (state_reg == S_WAIT);
  assign bus.done        = (state_reg == S_DONE);
endmodule

// File: tb/tb_c_guess_engine.sv
// Directed bench for c_guess_engine: hunt/target ordering, reset, full board,
// and a shallow-stack instance.
`timescale 1ns/1ps
module tb_c_guess_engine;
  localparam int CELLS = 28;
  localparam int IDXW  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  c_guess_engine_if #(.CELLS(CELLS), .IDXW(IDXW)) if0 ();
  c_guess_engine_if #(.CELLS(CELLS), .IDXW(IDXW)) if1 ();

  c_guess_engine #(.ROWS(4), .COLS(7)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  c_guess_engine #(.ROWS(4), .COLS(7), .TGT_DEPTH(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, steps on every non-reset edge.
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  int checks;
  int errors;
  logic [63:0] m_mask [2];

  function automatic logic [63:0] obs_comp(input int d);
    if (d == 0) return 64'(if0.comp_guess);
    return 64'(if1.comp_guess);
  endfunction
  function automatic logic [63:0] obs_sing(input int d);
    if (d == 0) return 64'(if0.sing_guess);
    return 64'(if1.sing_guess);
  endfunction
  function automatic logic [63:0] obs_idx(input int d);
    if (d == 0) return 64'(if0.guess_idx);
    return 64'(if1.guess_idx);
  endfunction
  function automatic logic obs_gv(input int d);
    if (d == 0) return if0.guess_valid;
    return if1.guess_valid;
  endfunction
  function automatic logic obs_busy(input int d);
    if (d == 0) return if0.busy;
    return if1.busy;
  endfunction
  function automatic logic obs_done(input int d);
    if (d == 0) return if0.done;
    return if1.done;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int d, input logic s, input logic hv, input logic h);
    if (d == 0) begin
      if0.sel = s; if0.hit_valid = hv; if0.hit = h;
    end else begin
      if1.sel = s; if1.hit_valid = hv; if1.hit = h;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    drv(0, 1'b0, 1'b0, 1'b0);
    drv(1, 1'b0, 1'b0, 1'b0);
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    m_mask[0] = '0;
    m_mask[1] = '0;
  endtask

  // One request/guess/answer transaction. exp_in < 0 means a hunt guess whose
  // index and latency are predicted from the reference LFSR and guessed mask.
  task automatic do_guess(input int d, input int force_c, input int exp_in, input int exp_lat,
                          input bit answer, input bit h, input string tag, output int exp_out);
    int e;
    int lat_exp;
    int n;
    int lat;
    int c;
    bit seen;
    logic [63:0] onehot;
    if (force_c >= 0) begin
      n = 0;
      while ((int'(m_lfsr) % CELLS) != force_c && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (exp_in < 0) begin
      c = int'(m_lfsr) % CELLS;
      lat_exp = 2;
      for (int i = 0; i < CELLS && m_mask[d][c]; i++) begin
        c = (c == CELLS - 1) ? 0 : c + 1;
        lat_exp++;
      end
      e = c;
    end else begin
      e = exp_in;
      lat_exp = exp_lat;
    end
    drv(d, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drv(d, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    lat = 0;
    for (int k = 1; k <= 80 && !seen; k++) begin
      @(posedge clk); #1;
      if (obs_gv(d)) begin
        seen = 1'b1;
        lat = k;
      end
    end
    onehot = 64'd1 << e;
    chk({tag, "_valid"}, 64'(seen), 64'd1);
    if (lat_exp >= 0) chk({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    chk({tag, "_idx"}, obs_idx(d), 64'(e));
    chk({tag, "_sing"}, obs_sing(d), onehot);
    chk({tag, "_comp"}, obs_comp(d), m_mask[d] | onehot);
    chk({tag, "_busy"}, 64'(obs_busy(d)), 64'd1);
    $display("guess %s dut%0d idx=%0d latency=%0d hit=%0d", tag, d, obs_idx(d), lat, h);
    m_mask[d] = m_mask[d] | onehot;
    if (answer) begin
      drv(d, 1'b0, 1'b1, h);
      @(posedge clk); #1;
      drv(d, 1'b0, 1'b0, 1'b0);
      chk({tag, "_idle"}, 64'(obs_busy(d)), 64'd0);
    end
    exp_out = e;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea [3];
    int x;
    int vcount;
    checks = 0;
    errors = 0;
    if0.sw = 1'b1; if0.phase = 1'b1;
    if1.sw = 1'b1; if1.phase = 1'b1;
    drv(0, 1'b0, 1'b0, 1'b0);
    drv(1, 1'b0, 1'b0, 1'b0);

    // Power-up reset and reset state
    do_reset(2);
    chk("rst_comp", obs_comp(0), 64'd0);
    chk("rst_sing", obs_sing(0), 64'd0);
    chk("rst_idx", obs_idx(0), 64'd0);
    chk("rst_valid", 64'(obs_gv(0)), 64'd0);
    chk("rst_busy", 64'(obs_busy(0)), 64'd0);
    chk("rst_done", 64'(obs_done(0)), 64'd0);
    chk("rst_comp1", obs_comp(1), 64'd0);

    // Test 1: three hunt guesses, reset mid-WAIT, same sequence again
    do_guess(0, -1, -1, -1, 1'b1, 1'b0, "t1a_0", ea[0]);
    do_guess(0, -1, -1, -1, 1'b1, 1'b0, "t1a_1", ea[1]);
    do_guess(0, -1, -1, -1, 1'b0, 1'b0, "t1a_2", ea[2]);
    do_reset(1);
    chk("t1_rst_comp", obs_comp(0), 64'd0);
    chk("t1_rst_sing", obs_sing(0), 64'd0);
    chk("t1_rst_valid", 64'(obs_gv(0)), 64'd0);
    chk("t1_rst_busy", 64'(obs_busy(0)), 64'd0);
    chk("t1_rst_done", 64'(obs_done(0)), 64'd0);
    do_guess(0, -1, ea[0], -1, 1'b1, 1'b0, "t1b_0", x);
    do_guess(0, -1, ea[1], -1, 1'b1, 1'b0, "t1b_1", x);
    do_guess(0, -1, ea[2], -1, 1'b1, 1'b0, "t1b_2", x);

    // Requests are ignored outside the game phase or the computer's turn
    if0.phase = 1'b0;
    drv(0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("phase0_busy", 64'(obs_busy(0)), 64'd0);
    if0.phase = 1'b1;
    if0.sw = 1'b0;
    drv(0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("sw0_busy", 64'(obs_busy(0)), 64'd0);
    if0.sw = 1'b1;

    // Test 2: hit at 8 -> 9, 7, 15, 1 then hunt
    do_reset(1);
    do_guess(0, 8, 8, 2, 1'b1, 1'b1, "t2_h8", x);
    do_guess(0, -1, 9, 2, 1'b1, 1'b0, "t2_9", x);
    do_guess(0, -1, 7, 2, 1'b1, 1'b0, "t2_7", x);
    do_guess(0, -1, 15, 2, 1'b1, 1'b0, "t2_15", x);
    do_guess(0, -1, 1, 2, 1'b1, 1'b0, "t2_1", x);
    do_guess(0, 20, 20, 2, 1'b1, 1'b0, "t2_hunt20", x);

    // Test 3: corner hit at 0 -> 1 then 7
    do_reset(1);
    do_guess(0, 0, 0, 2, 1'b1, 1'b1, "t3_h0", x);
    do_guess(0, -1, 1, 2, 1'b1, 1'b0, "t3_1", x);
    do_guess(0, -1, 7, 2, 1'b1, 1'b0, "t3_7", x);
    do_guess(0, 3, 3, 2, 1'b1, 1'b0, "t3_hunt3", x);

    // Test 4: right-edge hit at 13 -> 12, 20, 6; hit_valid in READY ignored
    do_guess(0, 13, 13, 2, 1'b1, 1'b1, "t4_h13", x);
    do_guess(0, -1, 12, 2, 1'b1, 1'b0, "t4_12", x);
    do_guess(0, -1, 20, 2, 1'b1, 1'b0, "t4_20", x);
    do_guess(0, -1, 6, 2, 1'b1, 1'b0, "t4_6", x);
    do_guess(0, 25, 25, 2, 1'b1, 1'b0, "t4_hunt25", x);
    drv(0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b0, 1'b0);
    chk("t4_stray_busy", 64'(obs_busy(0)), 64'd0);
    do_guess(0, 5, 5, 2, 1'b1, 1'b0, "t4_hunt5", x);

    // Chained hits leave a stale 17 in the stack; it is skipped at pop
    do_reset(1);
    do_guess(0, 10, 10, 2, 1'b1, 1'b1, "t7_h10", x);
    do_guess(0, -1, 11, 2, 1'b1, 1'b0, "t7_11", x);
    do_guess(0, -1, 9, 2, 1'b1, 1'b1, "t7_h9", x);
    do_guess(0, -1, 8, 2, 1'b1, 1'b0, "t7_8", x);
    do_guess(0, -1, 16, 2, 1'b1, 1'b1, "t7_h16", x);
    do_guess(0, -1, 17, 2, 1'b1, 1'b0, "t7_17", x);
    do_guess(0, -1, 15, 2, 1'b1, 1'b0, "t7_15", x);
    do_guess(0, -1, 23, 2, 1'b1, 1'b0, "t7_23", x);
    do_guess(0, -1, 2, 2, 1'b1, 1'b0, "t7_2", x);
    do_guess(0, -1, 3, 3, 1'b1, 1'b0, "t7_3skip", x);
    do_guess(0, 27, 27, 2, 1'b1, 1'b0, "t7_hunt27", x);

    // Test 5: full board of misses, then DONE ignores everything
    do_reset(1);
    for (int i = 0; i < CELLS; i++) begin
      do_guess(0, -1, -1, -1, 1'b1, 1'b0, $sformatf("t5_%0d", i), x);
    end
    chk("t5_done", 64'(obs_done(0)), 64'd1);
    chk("t5_comp_full", obs_comp(0), 64'h0FFF_FFFF);
    chk("t5_busy", 64'(obs_busy(0)), 64'd0);
    vcount = 0;
    drv(0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (obs_gv(0)) vcount++;
      @(posedge clk); #1;
    end
    chk("t5_no_guess", 64'(vcount), 64'd0);
    chk("t5_done_hold", 64'(obs_done(0)), 64'd1);
    chk("t5_comp_hold", obs_comp(0), 64'h0FFF_FFFF);
    $display("full board dut0 done=%0d comp=%0h", obs_done(0), obs_comp(0));

    // Test 6: two-deep stack keeps only N and S of a hit at 8
    do_reset(1);
    do_guess(1, 8, 8, 2, 1'b1, 1'b1, "t6_h8", x);
    do_guess(1, -1, 15, 2, 1'b1, 1'b0, "t6_15", x);
    do_guess(1, -1, 1, 2, 1'b1, 1'b0, "t6_1", x);
    do_guess(1, 20, 20, 2, 1'b1, 1'b0, "t6_hunt20", x);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/c_guess_engine.md
Name: c_guess_engine

Overview:
- Parametrised computer-opponent guess generator for the Battleship game phase.
- Replaces the fixed 28-entry guess sequence with an LFSR-driven hunt mode that never repeats a cell, plus a target mode that fires on the neighbours of confirmed hits.
- Drives the player-board hit-check logic and receives each guess's hit/miss result back.
- Exports the cumulative guess mask and a one-hot single guess, so the board display logic connects unchanged.

Parameters:
- ROWS, 4, board rows.
- COLS, 7, board columns; cell index = row*COLS + col, so index 0 is top-left.
- CELLS, ROWS*COLS, number of cells; must be ≤ 64.
- IDXW, $clog2(CELLS), width of a cell index.
- TGT_DEPTH, 8, depth of the target stack (LIFO).
- LFSR_SEED, 8'hA5, initial LFSR value; must be nonzero.

Ports:
- clk  in  1  game clock (4 Hz tick domain).
- rst  in  1  synchronous, active-high reset.
- sel  in  1  hit-select strobe from the player controls.
- sw  in  1  1 = computer's turn.
- phase  in  1  1 = game phase; 0 = placement phase.
- hit_valid  in  1  one-cycle strobe; the result for the outstanding guess is present.
- hit  in  1  result qualified by hit_valid: 1 = hit, 0 = miss.
- comp_guess  out  CELLS  cumulative mask of every cell guessed so far.
- sing_guess  out  CELLS  one-hot mask of the most recent guess.
- guess_idx  out  IDXW  index of the most recent guess.
- guess_valid  out  1  one-cycle pulse when a new guess is issued.
- busy  out  1  1 while in SEEK, ISSUE or WAIT.
- done  out  1  1 once all CELLS cells have been guessed.

Behaviour:
- Reset (one clk edge with rst=1), applied in any state including mid-SEEK or WAIT:
  - comp_guess, sing_guess, guess_idx, guess_valid and done go to 0.
  - The stack is emptied, the guess count cleared and the LFSR reloaded with LFSR_SEED.
  - The FSM goes to READY.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every non-reset cycle.
  - Hunt candidate = lfsr % CELLS, sampled on READY→SEEK.
- req = sw & sel & phase, evaluated each cycle.
- READY: if req, go to SEEK; otherwise hold. req outside READY is ignored (no queueing).
- SEEK examines one candidate per cycle:
  - Target mode (stack non-empty): pop the top entry. If that cell is already guessed, stay in SEEK and pop again. If unguessed, latch it and go to ISSUE.
  - If the stack empties during SEEK, fall back to hunt mode using the current hunt candidate.
  - Hunt mode: if the candidate is unguessed, latch it and go to ISSUE. Otherwise candidate = candidate+1, wrapping from CELLS-1 to 0; stay in SEEK.
  - Worst case is CELLS cycles.
- ISSUE, exactly one cycle:
  - comp_guess |= 1<<idx; sing_guess = 1<<idx; guess_idx = idx.
  - guess_valid = 1 for this cycle; guess count +1.
  - Go to WAIT.
- WAIT: hold until hit_valid. hit_valid in any other state is ignored.
  - On hit_valid with hit=1, push the neighbours of guess_idx in the order N (idx-COLS), S (idx+COLS), W (idx-1), E (idx+1). Pop order is therefore E, W, S, N.
  - A neighbour is pushed only if it is in-bounds (no row wrap: W requires col≠0, E requires col≠COLS-1) and not already guessed.
  - All pushes complete in the same cycle.
  - Neighbours that do not fit in a full stack are dropped.
  - Duplicate stack entries are allowed; they are filtered at pop.
  - Next state: DONE if guess count == CELLS, else READY.
- DONE: done=1. All req and hit_valid are ignored until rst. The outputs hold their last values.
- Latency: req in READY → guess_valid exactly 2 cycles later when the first candidate is unguessed; add one cycle per skipped candidate.
- busy = 1 in SEEK, ISSUE and WAIT; 0 in READY and DONE.

Test Plan (ROWS=4, COLS=7 unless stated):
1. Pulse rst mid-WAIT after 3 guesses -> next cycle comp_guess=0, done=0, busy=0; the next guess sequence is identical to the post-power-up sequence.
2. Force the first hunt guess to idx 8, answer hit=1 -> the next four guesses are 9, 7, 15, 1 in that order; the fifth reverts to hunt mode.
3. Force a hit at idx 0 -> only 7 and 1 are pushed; the next guesses are 1 then 7.
4. Force a hit at idx 13 (col 6) -> 14 is not pushed; the next guesses are 12, 20, 6.
5. Issue 28 requests, each answered hit=0 -> each index 0..27 appears exactly once, comp_guess=28'hFFFFFFF, done=1; a 29th req produces no guess_valid.
6. TGT_DEPTH=2, hit at idx 8 -> only N(1) and S(15) are stored; the next guesses are 15 then 1, after which hunt mode resumes.
